// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: defaults, saturation constants and the FSM state type
// shared by the fixed-point multiplier and divider.
package fixed_point_pkg;

    localparam int FP_WIDTH     = 16;
    localparam int FP_FRAC_BITS = 10;

    localparam logic [15:0] FP_SAT_POS = 16'h7FFF;
    localparam logic [15:0] FP_SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/divider_restoring_step.sv
// divider_restoring_step: one combinational restoring-division iteration.
// The dividend and the quotient share one shift register: the next dividend
// bit leaves at the top while the new quotient bit enters at the bottom.
module divider_restoring_step #(
    parameter int REM_W = 18,
    parameter int DSR_W = 17,
    parameter int QN    = 26
) (
    input  logic [REM_W-1:0] rem_i,
    input  logic [QN-1:0]    dq_i,
    input  logic [DSR_W-1:0] dsr_i,
    output logic [REM_W-1:0] rem_o,
    output logic [QN-1:0]    dq_o
);

    localparam int SW = REM_W + 1;

    logic [SW-1:0] shifted;
    logic [SW-1:0] diff;

    // Shift in the next dividend bit, trial-subtract, restore on a negative difference
    always_comb begin
        shifted = {rem_i, dq_i[QN-1]};
        diff    = shifted - SW'(dsr_i);
        if (diff[SW-1]) begin
            rem_o = shifted[REM_W-1:0];
            dq_o  = {dq_i[QN-2:0], 1'b0};
        end else begin
            rem_o = diff[REM_W-1:0];
            dq_o  = {dq_i[QN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider_restoring.sv
// divider_restoring: sequential signed fixed-point divider, one quotient bit
// per cycle, with saturation and divide-by-zero reporting.
// Optional macro DIVIDER_ROUND_EN: compute one guard quotient bit and round
// the magnitude half away from zero (adds one cycle of latency).
module divider_restoring
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = FP_WIDTH,
    parameter int FRAC_BITS = FP_FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag,
    output logic             finish
);

`ifdef DIVIDER_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif

    localparam int N      = WIDTH + FRAC_BITS;
    localparam int QN     = N + GUARD;
    localparam int REM_W  = WIDTH + 2;
    localparam int MAG_W  = N + 1;
    localparam int CNT_W  = $clog2(QN + 1);

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(QN);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SAT_P   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_N   = {1'b1, {(WIDTH-1){1'b0}}};

    fsm_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;
    logic             a_neg_q;
    logic             dbz_q;
    logic [REM_W-1:0] rem_q;
    logic [QN-1:0]    dq_q;
    logic [WIDTH:0]   dsr_q;
    logic [REM_W-1:0] rem_d;
    logic [QN-1:0]    dq_d;
    logic             accept;

    // Unsigned magnitude; 0x8000 maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        abs_mag = v[WIDTH-1] ? (~v + ONE) : v;
    endfunction

    // Collapse the raw quotient to the final magnitude (guard bit rounds half away from zero)
    function automatic logic [MAG_W-1:0] round_mag(input logic [QN-1:0] q);
`ifdef DIVIDER_ROUND_EN
        round_mag = MAG_W'(q[QN-1:1]) + MAG_W'(q[0]);
`else
        round_mag = MAG_W'(q);
`endif
    endfunction

    // Apply the sign and clamp; returns {overflow, result}
    function automatic logic [WIDTH:0] saturate(input logic neg, input logic [MAG_W-1:0] mag);
        if (!neg && (mag > MAG_W'(SAT_P))) begin
            saturate = {1'b1, SAT_P};
        end else if (neg && (mag > MAG_W'(SAT_N))) begin
            saturate = {1'b1, SAT_N};
        end else if (neg) begin
            saturate = {1'b0, ~mag[WIDTH-1:0] + ONE};
        end else begin
            saturate = {1'b0, mag[WIDTH-1:0]};
        end
    endfunction

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    divider_restoring_step #(
        .REM_W (REM_W),
        .DSR_W (WIDTH + 1),
        .QN    (QN)
    ) u_step (
        .rem_i (rem_q),
        .dq_i  (dq_q),
        .dsr_i (dsr_q),
        .rem_o (rem_d),
        .dq_o  (dq_d)
    );

    // Datapath: load magnitudes on accept, advance one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q <= '0;
            dq_q  <= QN'(abs_mag(A)) << (FRAC_BITS + GUARD);
            dsr_q <= {1'b0, abs_mag(B)};
        end else if (state_q == CALC) begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
        end
    end

    // Control FSM with registered result, overflow and finish
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sign_q        <= 1'b0;
            a_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            result        <= '0;
            overflow_flag <= 1'b0;
            finish        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sign_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                        a_neg_q <= A[WIDTH-1];
                        dbz_q   <= (B == '0);
                        cnt_q   <= '0;
                        finish  <= 1'b0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (dbz_q) begin
                        // Divide by zero: no iterations, saturate toward the dividend's sign
                        result        <= a_neg_q ? SAT_N : SAT_P;
                        overflow_flag <= 1'b1;
                        finish        <= 1'b1;
                        state_q       <= DONE;
                    end else if (cnt_q == CNT_END) begin
                        // All iterations done: the quotient register now holds the full magnitude
                        {overflow_flag, result} <= saturate(sign_q, round_mag(dq_q));
                        finish                  <= 1'b1;
                        state_q                 <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_restoring.sv
// tb_divider_restoring: randomized and directed checks of the divider against
// an arithmetic reference model.
module tb_divider_restoring;
    import fixed_point_pkg::*;

`ifdef DIVIDER_ROUND_EN
    localparam int LAT = 28;
`else
    localparam int LAT = 27;
`endif
    localparam int FRAC  = 10;
    localparam int BOUND = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        start = 1'b0;
    logic [15:0] result;
    logic        overflow_flag;
    logic        finish;

    int checks = 0;
    int errors = 0;

    divider_restoring dut (
        .clk           (clk),
        .rst           (rst),
        .A             (A),
        .B             (B),
        .start         (start),
        .result        (result),
        .overflow_flag (overflow_flag),
        .finish        (finish)
    );

    always #5 clk = ~clk;

    // Reference: exact rational quotient, truncated (or rounded) then clamped
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic o);
        longint sa, sb, ma, mb, q;
        bit neg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            r = (sa < 0) ? FP_SAT_NEG : FP_SAT_POS;
            o = 1'b1;
            return;
        end
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        neg = (a[15] != b[15]);
`ifdef DIVIDER_ROUND_EN
        q = ((ma * (longint'(1) << (FRAC + 1))) + mb) / (2 * mb);
`else
        q = (ma * (longint'(1) << FRAC)) / mb;
`endif
        if (!neg && q > 32767) begin
            r = FP_SAT_POS; o = 1'b1;
        end else if (neg && q > 32768) begin
            r = FP_SAT_NEG; o = 1'b1;
        end else begin
            r = neg ? 16'(-q) : 16'(q);
            o = 1'b0;
        end
    endfunction

    // One full operation: accept, scramble operands, wait for finish, compare
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string name);
        logic [15:0] er;
        logic        eo;
        int          el;
        int          cyc;
        model(a, b, er, eo);
        el = (b == 16'h0) ? 1 : LAT;
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom);
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("FAIL %s finish_after_accept: got %b want 0", name, finish);
        end
        cyc = 0;
        while (finish !== 1'b1 && cyc < BOUND) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== el) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, el);
        end
        checks++;
        if (result !== er) begin
            errors++;
            $display("FAIL %s result: A=%h B=%h got %h want %h", name, a, b, result, er);
        end
        checks++;
        if (overflow_flag !== eo) begin
            errors++;
            $display("FAIL %s overflow: A=%h B=%h got %b want %b", name, a, b, overflow_flag, eo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (result !== 16'h0) begin
            errors++; $display("FAIL reset result: got %h want 0000", result);
        end
        checks++;
        if (overflow_flag !== 1'b0) begin
            errors++; $display("FAIL reset overflow: got %b want 0", overflow_flag);
        end
        checks++;
        if (finish !== 1'b0) begin
            errors++; $display("FAIL reset finish: got %b want 0", finish);
        end
    endtask

    task automatic test_directed();
        run_op(16'h0C00, 16'h0400, "3_div_1");
        run_op(16'h0800, 16'h0C00, "2_div_3");
        run_op(16'hF400, 16'h0800, "neg3_div_2");
        run_op(16'h8000, 16'hFC00, "min_div_neg1");
        run_op(16'h7000, 16'h0080, "pos_sat");
        run_op(16'h9000, 16'h0080, "neg_sat");
        run_op(16'h0000, 16'hF000, "zero_dividend");
        run_op(16'h8000, 16'h0400, "min_div_1");
        run_op(16'h0400, 16'h0000, "div0_pos");
        run_op(16'hFC00, 16'h0000, "div0_neg");
    endtask

    task automatic test_reset_mid();
        bit seen;
        A = 16'h0C00; B = 16'h0400; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (result !== 16'h0 || overflow_flag !== 1'b0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid outputs: got r=%h o=%b f=%b want 0/0/0", result, overflow_flag, finish);
        end
        seen = 1'b0;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (finish === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL reset_mid aborted_finish: got 1 want 0");
        end
        run_op(16'h0400, 16'h0400, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [15:0] r1, r2;
        logic        o1, o2;
        int          cyc;
        model(16'h1800, 16'h0800, r1, o1);
        model(16'hE800, 16'h0300, r2, o2);
        A = 16'h1800; B = 16'h0800; start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (finish !== 1'b1 && cyc < BOUND) begin
            @(posedge clk); #1; cyc++;
        end
        A = 16'hE800; B = 16'h0300;
        checks++;
        if (cyc !== LAT || result !== r1 || overflow_flag !== o1) begin
            errors++;
            $display("FAIL b2b first: got lat=%0d r=%h o=%b want lat=%0d r=%h o=%b", cyc, result, overflow_flag, LAT, r1, o1);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (finish !== 1'b0 || result !== r1) begin
            errors++;
            $display("FAIL b2b reaccept: got f=%b r=%h want f=0 r=%h", finish, result, r1);
        end
        cyc = 0;
        while (finish !== 1'b1 && cyc < BOUND) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc !== LAT || result !== r2 || overflow_flag !== o2) begin
            errors++;
            $display("FAIL b2b second: got lat=%0d r=%h o=%b want lat=%0d r=%h o=%b", cyc, result, overflow_flag, LAT, r2, o2);
        end
    endtask

    task automatic test_start_in_calc();
        logic [15:0] er;
        logic        eo;
        int          cyc;
        model(16'h0A00, 16'hFD00, er, eo);
        A = 16'h0A00; B = 16'hFD00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        A = 16'h0100; B = 16'h0000; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 7;
        while (finish !== 1'b1 && cyc < BOUND) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc !== LAT || result !== er || overflow_flag !== eo) begin
            errors++;
            $display("FAIL start_in_calc: got lat=%0d r=%h o=%b want lat=%0d r=%h o=%b", cyc, result, overflow_flag, LAT, er, eo);
        end
    endtask

    task automatic test_reset_start_same();
        bit seen;
        A = 16'h0400; B = 16'h0400; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        seen = 1'b0;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (finish === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || result !== 16'h0) begin
            errors++;
            $display("FAIL rst_and_start: got finish_seen=%b r=%h want 0 0000", seen, result);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom_range(1, 255));
                1: b = 16'($urandom_range(0, 255)) | 16'hFF00;
                default: b = 16'($urandom);
            endcase
            run_op(a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_start_in_calc();
        test_reset_start_same();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
